// File: rtl/uart_byte_tx.sv
// UART byte transmitter: small input FIFO feeding an 8-bit serialiser
// (LSB first, optional odd/even parity, 1 or 2 stop bits). Line outputs are registered.
module uart_byte_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          txStart,
  input  logic [7:0]                    txData,
  output logic                          txReady,
  output logic                          txBusy,
  output logic                          txDone,
  output logic                          txOut,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic STOP_LAST_IDX = (STOP_BITS == 2);
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic          bit_end, stop_last;
  logic          line_next, busy_next, done_next;
  logic          line_reg, busy_reg, done_reg;

  // Ready comes from the registered count only, so a same-cycle pop never admits a push at full.
  assign txReady   = (count < DEPTH);
  assign push      = txStart && txReady;
  assign pop       = (state == IDLE) && (count != '0);
  assign fifoCount = count;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign stop_last = (state == STOP) && bit_end && (stop_idx == STOP_LAST_IDX);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= txData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_next = (PARITY != 0) ? PAR : STOP;
      PAR:     if (bit_end) state_next = STOP;
      STOP:    if (stop_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        par_bit   <= (^mem[rd_ptr]) ^ ODD;
        bit_idx   <= '0;
        stop_idx  <= 1'b0;
      end else if (state == DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 3'd1;
      end else if (state == STOP && bit_end) begin
        stop_idx  <= ~stop_idx;
      end
    end
  end

  always_comb begin
    line_next = 1'b1;
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state)
      START: begin line_next = 1'b0;         busy_next = 1'b1; end
      DATA:  begin line_next = shift_reg[0]; busy_next = 1'b1; end
      PAR:   begin line_next = par_bit;      busy_next = 1'b1; end
      STOP:  begin busy_next = 1'b1;         done_next = stop_last; end
      default: ;
    endcase
  end

  // One register stage on the line keeps txOut glitch-free; it also sets the pop-to-start latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_reg <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      line_reg <= line_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  assign txOut  = line_reg;
  assign txBusy = busy_reg;
  assign txDone = done_reg;
endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: five parameterisations share one clock; stimulus queues expected
// frames, a per-instance line monitor decodes frames and checks them against that queue.
module tb_uart_byte_tx;
  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_v   [NI];
  logic       start_v [NI];
  logic [7:0] data_v  [NI];
  logic       ready_v [NI];
  logic       busy_v  [NI];
  logic       done_v  [NI];
  logic       line_v  [NI];
  logic [2:0] count_v [NI];

  logic [7:0] sb_data  [NI][16];
  logic       sb_par   [NI][16];
  int         sb_start [NI][16];
  int         sb_gap   [NI][16];
  int         sb_wr    [NI];
  int         sb_rd    [NI];

  int checks;
  int failures;

  uart_byte_tx #(.CLK_HZ(16), .BAUD(1), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_v[0]), .txStart(start_v[0]), .txData(data_v[0]), .txReady(ready_v[0]),
    .txBusy(busy_v[0]), .txDone(done_v[0]), .txOut(line_v[0]), .fifoCount(count_v[0]));
  uart_byte_tx #(.CLK_HZ(16), .BAUD(1), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_v[1]), .txStart(start_v[1]), .txData(data_v[1]), .txReady(ready_v[1]),
    .txBusy(busy_v[1]), .txDone(done_v[1]), .txOut(line_v[1]), .fifoCount(count_v[1]));
  uart_byte_tx #(.CLK_HZ(16), .BAUD(1), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_v[2]), .txStart(start_v[2]), .txData(data_v[2]), .txReady(ready_v[2]),
    .txBusy(busy_v[2]), .txDone(done_v[2]), .txOut(line_v[2]), .fifoCount(count_v[2]));
  uart_byte_tx #(.CLK_HZ(16), .BAUD(1), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_v[3]), .txStart(start_v[3]), .txData(data_v[3]), .txReady(ready_v[3]),
    .txBusy(busy_v[3]), .txDone(done_v[3]), .txOut(line_v[3]), .fifoCount(count_v[3]));
  uart_byte_tx #(.CLK_HZ(50000000), .BAUD(9600), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_v[4]), .txStart(start_v[4]), .txData(data_v[4]), .txReady(ready_v[4]),
    .txBusy(busy_v[4]), .txDone(done_v[4]), .txOut(line_v[4]), .fifoCount(count_v[4]));

  function automatic int div_of(input int k);
    return (k == 4) ? 5208 : 16;
  endfunction
  function automatic int par_of(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction
  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=0x%0h expected=0x%0h", name, k, got, exp);
    end
  endtask

  task automatic expect_frame(input int k, input logic [7:0] d, input logic p,
                              input int st, input int gap);
    int idx;
    idx = sb_wr[k] % 16;
    sb_data[k][idx]  = d;
    sb_par[k][idx]   = p;
    sb_start[k][idx] = st;
    sb_gap[k][idx]   = gap;
    sb_wr[k]++;
  endtask

  // Drive a push for the coming edge; n is that edge's number, acc the ready level it sees.
  task automatic push1(input int k, input logic [7:0] d, output int n, output logic acc);
    @(negedge clk);
    start_v[k] = 1'b1;
    data_v[k]  = d;
    acc        = ready_v[k];
    n          = cyc + 1;
  endtask

  task automatic drop(input int k);
    @(negedge clk);
    start_v[k] = 1'b0;
    data_v[k]  = ~data_v[k];
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic monitor(input int k);
    int div, npar, nslots, s0, last_end, idx;
    logic v, slotv, exp_done, p;
    logic [7:0] d;
    bit glitch, busy_bad, done_bad, framing_bad, aborted;
    div      = div_of(k);
    npar     = par_of(k);
    nslots   = 9 + npar + stop_of(k);
    last_end = -100000;
    slotv    = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_v[k]) begin
        sb_rd[k] = sb_wr[k];
        continue;
      end
      if (line_v[k] == 1'b0) begin
        s0 = cyc; glitch = 0; busy_bad = 0; done_bad = 0; framing_bad = 0; aborted = 0;
        d = '0; p = 1'b0;
        for (int j = 0; j < nslots && !aborted; j++) begin
          for (int c = 0; c < div && !aborted; c++) begin
            if (!(j == 0 && c == 0)) @(negedge clk);
            if (!rst_v[k]) aborted = 1;
            else begin
              v = line_v[k];
              if (c == 0) slotv = v;
              else if (v !== slotv) glitch = 1;
              if (busy_v[k] !== 1'b1) busy_bad = 1;
              exp_done = (j == nslots - 1) && (c == div - 1);
              if (done_v[k] !== exp_done) done_bad = 1;
            end
          end
          if (!aborted) begin
            if (j == 0) begin
              if (slotv !== 1'b0) framing_bad = 1;
            end else if (j <= 8) begin
              d[j-1] = slotv;
            end else if (j == 9 && npar != 0) begin
              p = slotv;
            end else if (slotv !== 1'b1) begin
              framing_bad = 1;
            end
          end
        end
        if (aborted) begin
          sb_rd[k] = sb_wr[k];
          $display("frame inst=%0d abandoned by reset at cyc=%0d", k, cyc);
        end else if (sb_rd[k] == sb_wr[k]) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame inst=%0d got=0x%02h expected=none", k, d);
        end else begin
          idx = sb_rd[k] % 16;
          sb_rd[k]++;
          $display("frame inst=%0d data=0x%02h par=%0b start_cyc=%0d", k, d, p, s0);
          check("data", k, d, sb_data[k][idx]);
          check("framing", k, {glitch, framing_bad}, 0);
          check("busy_in_frame", k, busy_bad, 0);
          check("done_pulse", k, done_bad, 0);
          if (npar != 0) check("parity", k, p, sb_par[k][idx]);
          if (sb_start[k][idx] >= 0) check("start_cycle", k, s0, sb_start[k][idx]);
          if (sb_gap[k][idx] >= 0) check("idle_gap", k, s0 - last_end - 1, sb_gap[k][idx]);
          last_end = cyc;
        end
      end
    end
  endtask

  task automatic seq_simple(input int k, input logic [7:0] d, input logic p, input int slots);
    int n;
    logic acc;
    push1(k, d, n, acc);
    expect_frame(k, d, p, n + 2, -1);
    drop(k);
    check("accept", k, acc, 1);
    wait_until(n + 2 + slots * div_of(k) + 3);
    check("busy_after", k, busy_v[k], 0);
    check("count_after", k, count_v[k], 0);
  endtask

  task automatic seq0();
    int n, n0, m, t;
    logic acc;
    logic [7:0] b;
    logic exp_acc [6];
    exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // single byte, latency and frame shape
    push1(0, 8'h36, n, acc);
    expect_frame(0, 8'h36, 1'b0, n + 2, -1);
    drop(0);
    check("t1_accept", 0, acc, 1);
    check("t1_count_after_push", 0, count_v[0], 1);
    wait_until(n + 2 + 160 + 4);
    check("t1_busy_after", 0, busy_v[0], 0);
    check("t1_line_after", 0, line_v[0], 1);
    // overfill: six consecutive pushes into a depth-4 FIFO
    n0 = 0;
    for (int i = 0; i < 6; i++) begin
      b = 8'(i);
      push1(0, b, n, acc);
      if (i == 0) n0 = n;
      if (i == 5) check("t3_peak_count", 0, count_v[0], 4);
      check("t3_accept", 0, acc, exp_acc[i]);
      if (exp_acc[i]) expect_frame(0, b, 1'b0, (i == 0) ? n + 2 : -1, (i == 0) ? -1 : 1);
    end
    drop(0);
    check("t3_drop_no_change", 0, count_v[0], 4);
    wait_until(n0 + 2 + 5 * 161 + 5);
    check("t3_count_drained", 0, count_v[0], 0);
    // push on the edge where txDone rises
    push1(0, 8'hA5, n, acc);
    expect_frame(0, 8'hA5, 1'b0, n + 2, -1);
    drop(0);
    wait_until(n + 160 - 1);
    push1(0, 8'h5A, m, acc);
    expect_frame(0, 8'h5A, 1'b0, m + 2, 1);
    drop(0);
    check("t6_accept", 0, acc, 1);
    check("t6_done_at_push", 0, done_v[0], 1);
    check("t6_count_queued", 0, count_v[0], 1);
    wait_until(m + 2 + 160 + 4);
    check("t6_count_drained", 0, count_v[0], 0);
    check("t6_busy_after", 0, busy_v[0], 0);
    // reset during data bit 3 with two bytes queued
    push1(0, 8'h11, n, acc);
    expect_frame(0, 8'h11, 1'b0, n + 2, -1);
    push1(0, 8'h22, t, acc);
    push1(0, 8'h33, t, acc);
    drop(0);
    check("t5_queued", 0, count_v[0], 2);
    wait_until(n + 2 + 4 * 16 + 8);
    #1 rst_v[0] = 1'b0;
    #1;
    check("t5_rst_line", 0, line_v[0], 1);
    check("t5_rst_busy", 0, busy_v[0], 0);
    check("t5_rst_count", 0, count_v[0], 0);
    check("t5_rst_ready", 0, ready_v[0], 1);
    check("t5_rst_done", 0, done_v[0], 0);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    t = cyc;
    wait_until(t + 5 * 16);
    check("t5_line_idle", 0, line_v[0], 1);
    check("t5_busy_idle", 0, busy_v[0], 0);
    check("t5_count_idle", 0, count_v[0], 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < NI; k++) begin
      rst_v[k] = 1'b0; start_v[k] = 1'b0; data_v[k] = 8'h00; sb_wr[k] = 0; sb_rd[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst_v[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_line", k, line_v[k], 1);
      check("rst_busy", k, busy_v[k], 0);
      check("rst_done", k, done_v[k], 0);
      check("rst_ready", k, ready_v[k], 1);
      check("rst_count", k, count_v[k], 0);
    end
    for (int k = 0; k < NI; k++) begin
      fork
        automatic int kk = k;
        monitor(kk);
      join_none
    end
    fork
      seq0();
      begin seq_simple(1, 8'h07, 1'b1, 11); seq_simple(1, 8'h36, 1'b0, 11); end
      begin seq_simple(2, 8'h07, 1'b0, 11); seq_simple(2, 8'h36, 1'b1, 11); end
      seq_simple(3, 8'hFF, 1'b0, 11);
      seq_simple(4, 8'h36, 1'b0, 10);
    join
    repeat (5) @(negedge clk);
    for (int k = 0; k < NI; k++) check("all_frames_seen", k, sb_wr[k] - sb_rd[k], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    wait (cyc >= 90000);
    checks++;
    failures++;
    $display("FAIL watchdog got=cyc%0d expected=finish_before_90000", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
